// File: rtl/pll_reconfig_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding and divider-code width for the PLL reconfiguration controller
package pll_ctrl_pkg;
   localparam int DIV_CODE_W = 6;
   typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/pll_reconfig_ctrl_sync2.sv
// sync2: two-flop synchronizer with asynchronous clear to 0
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge clk or posedge rst)
      if (rst) {q, m} <= 2'b00;
      else {q, m} <= {m, d};
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequences PLL reset, lock qualification, retries and dynamic divider reconfiguration
module pll_reconfig_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY = 3,
   parameter logic [DIV_CODE_W-1:0] DEF_IDSEL = 6'd0,
   parameter logic [DIV_CODE_W-1:0] DEF_FBDSEL = 6'd0,
   parameter logic [DIV_CODE_W-1:0] DEF_ODSEL = 6'd0
) (
   input  logic clk,
   input  logic rst,
   input  logic cfg_valid,
   input  logic [DIV_CODE_W-1:0] cfg_idsel,
   input  logic [DIV_CODE_W-1:0] cfg_fbdsel,
   input  logic [DIV_CODE_W-1:0] cfg_odsel,
   output logic cfg_ready,
   input  logic pll_lock,
   output logic pll_reset,
   output logic [DIV_CODE_W-1:0] pll_idsel,
   output logic [DIV_CODE_W-1:0] pll_fbdsel,
   output logic [DIV_CODE_W-1:0] pll_odsel,
   output logic locked,
   output logic rst_out,
   output logic err_timeout,
   output logic lock_lost,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
   state_t state, nxt;
   logic [CW-1:0] cnt, cnt_n;
   logic [RW-1:0] retry_n;
   logic lock_s, xfer;
   sync2 u_sync (.clk(clk), .rst(rst), .d(pll_lock), .q(lock_s));
   assign xfer = cfg_valid && cfg_ready;
   // one shared counter: each state restarts it on entry, so the phases never overlap
   always_comb begin
      nxt = state;
      cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
      retry_n = retry_cnt;
      case (state)
         RESET_PLL: if (cnt == CW'(RST_CYCLES - 1)) begin
            nxt = WAIT_LOCK;
            cnt_n = '0;
         end
         WAIT_LOCK: if (lock_s) begin
            nxt = STABLE;
            cnt_n = CW'(1);
         end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            cnt_n = '0;
            if (retry_cnt == RW'(MAX_RETRY)) nxt = FAIL;
            else begin
               nxt = RESET_PLL;
               retry_n = retry_cnt + 1'b1;
            end
         end
         STABLE: if (!lock_s) begin
            nxt = WAIT_LOCK;
            cnt_n = '0;
         end else if (cnt >= CW'(STABLE_CYCLES - 1)) begin
            nxt = RUN;
            cnt_n = '0;
         end
         RUN: if (!lock_s) begin
            nxt = RESET_PLL;
            cnt_n = '0;
         end
         FAIL: cnt_n = '0;
         default: nxt = RESET_PLL;
      endcase
      if (xfer) begin
         nxt = RESET_PLL;
         cnt_n = '0;
         retry_n = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESET_PLL;
         cnt <= '0;
         retry_cnt <= '0;
         pll_reset <= 1'b1;
         locked <= 1'b0;
         rst_out <= 1'b1;
         cfg_ready <= 1'b0;
         err_timeout <= 1'b0;
         lock_lost <= 1'b0;
         pll_idsel <= DEF_IDSEL;
         pll_fbdsel <= DEF_FBDSEL;
         pll_odsel <= DEF_ODSEL;
      end else begin
         state <= nxt;
         cnt <= cnt_n;
         retry_cnt <= retry_n;
         pll_reset <= (nxt == RESET_PLL) || (nxt == FAIL);
         locked <= nxt == RUN;
         rst_out <= nxt != RUN;
         cfg_ready <= (nxt == RUN) || (nxt == FAIL);
         if (state == RUN && !lock_s) lock_lost <= 1'b1;
         // codes move only on the edge that also raises pll_reset
         if (xfer) begin
            pll_idsel <= cfg_idsel;
            pll_fbdsel <= cfg_fbdsel;
            pll_odsel <= cfg_odsel;
            err_timeout <= 1'b0;
         end else if (nxt == FAIL) err_timeout <= 1'b1;
      end
   end
endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_reset is held high per reset attempt (minimum 2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles allowed in WAIT_LOCK before the attempt fails.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before RUN.
REQ-004 SHALL have parameter MAX_RETRY, default 3: failed attempts allowed before FAIL.
REQ-005 SHALL have parameters DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL, each 6 bits: raw dynamic-divider codes applied after reset.
REQ-006 clk  in  1  reference clock (PLL input clock); all logic is in this domain.
REQ-007 rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-008 cfg_valid  in  1  new divider set offered.
REQ-009 cfg_idsel, cfg_fbdsel, cfg_odsel  in  6 each  offered raw codes.
REQ-010 cfg_ready  out  1  a new configuration can be accepted.
REQ-011 pll_lock  in  1  PLL LOCK, asynchronous to clk.
REQ-012 pll_reset  out  1  drives PLL RESET.
REQ-013 pll_idsel, pll_fbdsel, pll_odsel  out  6 each  drive PLL IDSEL/FBDSEL/ODSEL.
REQ-014 locked  out  1  high only in RUN.
REQ-015 rst_out  out  1  downstream synchronous reset, high in every state except RUN.
REQ-016 err_timeout  out  1  sticky; set on entry to FAIL.
REQ-017 lock_lost  out  1  sticky; set when lock drops in RUN.
REQ-018 retry_cnt  out  $clog2(MAX_RETRY+1)  failed attempts in the current configuration.

Function
REQ-019 pll_lock SHALL be passed through a 2-FF synchronizer; all lock decisions SHALL use the synchronized value.
REQ-020 States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL.
REQ-021 RESET_PLL: pll_reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with the timeout counter cleared.
REQ-022 WAIT_LOCK: pll_reset=0; on synced lock=1 go to STABLE; if the counter reaches LOCK_TIMEOUT-1 without lock, increment retry_cnt and go to RESET_PLL, or to FAIL if retry_cnt already equals MAX_RETRY.
REQ-023 STABLE: count consecutive lock=1 cycles; lock=0 returns to WAIT_LOCK with the timeout counter cleared; after STABLE_CYCLES consecutive cycles go to RUN.
REQ-024 RUN: locked=1 and rst_out=0 in the same cycle; synced lock=0 sets lock_lost and goes to RESET_PLL; retry_cnt is not incremented.
REQ-025 FAIL: pll_reset=1 continuously; remains in FAIL until a configuration is accepted.
REQ-026 cfg_ready=1 only in RUN and FAIL; a transfer occurs when cfg_valid and cfg_ready are both high on a clk edge.
REQ-027 Transfer: latch the three codes onto the pll_*sel outputs on the next cycle; clear retry_cnt and err_timeout; go to RESET_PLL. lock_lost is not cleared.
REQ-028 Transfer in the same cycle as a lock drop in RUN: the transfer wins; lock_lost is still set.
REQ-029 cfg_valid outside RUN/FAIL SHALL be ignored, with no state change.
REQ-030 pll_*sel SHALL change only on a transfer, never while pll_reset=0.
REQ-031 Counters SHALL saturate; they SHALL not wrap.

Reset
REQ-032 On rst: state=RESET_PLL (cycle count 0), pll_reset=1, pll_*sel=DEF_*, rst_out=1, locked=0, cfg_ready=0, err_timeout=0, lock_lost=0, retry_cnt=0, synchronizer=0.
REQ-033 rst asserted mid-operation SHALL abort any state immediately, including a FAIL or pending transfer.

Structure
REQ-034 Shared package pll_ctrl_pkg: state enum, DIV_CODE_W=6 constant.
REQ-035 One sub-module, sync2 (2-FF synchronizer with asynchronous reset to 0).
REQ-036 The PLL primitive SHALL stay outside this block; the block drives the primitive's dynamic-select ports.

Verification
REQ-037 Bench SHALL use a PLL model with lock delay 300 and RST_CYCLES=16, STABLE_CYCLES=64: release rst -> pll_reset falls at cycle 16; locked/rst_out flip 2+64 cycles after lock rises; codes equal DEF_*.
REQ-038 Bench SHALL use LOCK_TIMEOUT=100, MAX_RETRY=3, lock stuck 0 -> 4 reset pulses, then FAIL with err_timeout=1, retry_cnt=3, pll_reset=1, cfg_ready=1.
REQ-039 In RUN, offer codes 0x01/0x3B/0x38 -> pll_*sel update on the next cycle, rst_out=1, locked=0, and relock completes with the new codes.
REQ-040 In RUN, drop lock for 1 cycle -> lock_lost=1, RESET_PLL entered, retry_cnt unchanged, and RUN is re-entered after relock.
REQ-041 In STABLE, glitch lock low at stable count 30 -> WAIT_LOCK, and RUN is delayed by a full 64-cycle requalification.
REQ-042 Assert rst during WAIT_LOCK and during FAIL -> all outputs match REQ-032 asynchronously.
